ps2_mouse_sequencer: RTL and testbench

Sequences a PS2_Controller instance (built with INITIALIZE_MOUSE=0) to bring up a PS/2 mouse: reset, BAT/ID check, enable streaming. After bring-up it assembles the 3-byte stream packets into button and 9-bit delta outputs for the CPU-side peripheral registers.
It handles retry, resend (0xFE) and timeout recovery, and re-synchronises packets. It sits between PS2_Controller and the memory-mapped mouse register block.

---
 rtl/ps2_mouse_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_mouse_sequencer
//
// Brings up a PS/2 mouse through a PS2_Controller (built without its own
// mouse init): sends reset (FF), checks ACK/BAT/ID, enables streaming (F4),
// then assembles 3-byte stream packets into button/delta outputs for the
// CPU-side mouse registers. Retries failed init attempts, resends on FE,
// times out silent mice, and re-synchronises the packet stream.
//
// Ports
//   CLOCK_50                       system clock
//   reset                          synchronous active-low reset
//   restart                        one-cycle pulse, rerun init from SEND_RST
//   the_command / send_command     command byte and level request to controller
//   command_was_sent               controller finished sending the command
//   error_communication_timed_out  controller gave up sending the command
//   received_data/_en              byte from the mouse, one-cycle strobe
//   init_done                      mouse is streaming
//   init_error                     retries exhausted (sticky until reset/restart)
//   buttons/dx/dy/overflow         fields of the last valid stream packet
//   packet_valid                   one-cycle strobe, new packet on the outputs
//
// state        | meaning
// -------------+----------------------------------------------------------
// SEND_RST     | load FF, raise send_command
// WAIT_SENT    | controller is shifting FF out
// WAIT_ACK     | expect FA (FE = resend)
// WAIT_BAT     | expect AA self-test pass
// WAIT_ID      | expect 00 device id
// SEND_EN      | load F4, raise send_command
// WAIT_SENT_EN | controller is shifting F4 out
// WAIT_ACK_EN  | expect FA (FE = resend F4)
// STREAM       | assembling stream packets
// FAILED       | retries exhausted, ignore everything until restart
// ---------------------------------------------------------------------------
module ps2_mouse_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned PKT_GAP_CYCLES = 100_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       restart,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       init_done,
    output logic       init_error,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [1:0] overflow,
    output logic       packet_valid
);

    localparam int unsigned TMAX = (TIMEOUT_CYCLES > PKT_GAP_CYCLES) ?
                                   TIMEOUT_CYCLES : PKT_GAP_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] T_ACK_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP_LAST = TW'(PKT_GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT      = '1;
    localparam logic [RW-1:0] R_MAX      = RW'(MAX_RETRIES);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [3:0] {
        SEND_RST,
        WAIT_SENT,
        WAIT_ACK,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_SENT_EN,
        WAIT_ACK_EN,
        STREAM,
        FAILED
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      the_command_q, the_command_d;
    logic            send_command_q, send_command_d;
    logic            init_done_q, init_done_d;
    logic            init_error_q, init_error_d;
    logic [7:0]      b0_q, b0_d;
    logic [7:0]      b1_q, b1_d;
    logic [7:0]      b2_q, b2_d;
    logic            pkt_pend_q, pkt_pend_d;
    logic [2:0]      buttons_q, buttons_d;
    logic [8:0]      dx_q, dx_d;
    logic [8:0]      dy_q, dy_d;
    logic [1:0]      overflow_q, overflow_d;
    logic            packet_valid_q, packet_valid_d;
    // A reply can land while the controller still reports the command as
    // in flight; it is parked here and consumed in the following WAIT_ACK*.
    logic            hold_q, hold_d;
    logic [7:0]      hold_byte_q, hold_byte_d;

    logic            do_retry;
    logic            do_resend;
    logic            rx_v;
    logic [7:0]      rx_byte;
    logic [RW-1:0]   retry_inc;

    always_comb begin
        state_d        = state_q;
        retry_cnt_d    = retry_cnt_q;
        timer_d        = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
        byte_idx_d     = byte_idx_q;
        the_command_d  = the_command_q;
        send_command_d = send_command_q;
        init_done_d    = init_done_q;
        init_error_d   = init_error_q;
        b0_d           = b0_q;
        b1_d           = b1_q;
        b2_d           = b2_q;
        pkt_pend_d     = 1'b0;
        buttons_d      = buttons_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        overflow_d     = overflow_q;
        packet_valid_d = 1'b0;
        hold_d         = hold_q;
        hold_byte_d    = hold_byte_q;
        do_retry       = 1'b0;
        do_resend      = 1'b0;
        rx_v           = hold_q | received_data_en;
        rx_byte        = hold_q ? hold_byte_q : received_data;
        retry_cnt_d    = retry_cnt_q;
        retry_inc      = retry_cnt_q + RW'(1);

        // Third byte was captured last cycle: publish the packet now.
        if (pkt_pend_q) begin
            buttons_d      = b0_q[2:0];
            dx_d           = {b0_q[4], b1_q};
            dy_d           = {b0_q[5], b2_q};
            overflow_d     = b0_q[7:6];
            packet_valid_d = 1'b1;
        end

        unique case (state_q)
            SEND_RST: begin
                the_command_d  = CMD_RESET;
                send_command_d = 1'b1;
                hold_d         = 1'b0;
                timer_d        = '0;
                state_d        = WAIT_SENT;
            end
            SEND_EN: begin
                the_command_d  = CMD_ENABLE;
                send_command_d = 1'b1;
                hold_d         = 1'b0;
                timer_d        = '0;
                state_d        = WAIT_SENT_EN;
            end
            WAIT_SENT, WAIT_SENT_EN: begin
                if (received_data_en) begin
                    hold_d      = 1'b1;
                    hold_byte_d = received_data;
                end
                if (command_was_sent) begin
                    send_command_d = 1'b0;
                    timer_d        = '0;
                    state_d        = (state_q == WAIT_SENT) ? WAIT_ACK : WAIT_ACK_EN;
                end else if (error_communication_timed_out) begin
                    do_retry = 1'b1;
                end
            end
            WAIT_ACK, WAIT_BAT, WAIT_ID, WAIT_ACK_EN: begin
                if (rx_v) begin
                    // A fresh byte arriving while a parked one is consumed
                    // becomes the new parked byte.
                    hold_d = hold_q & received_data_en;
                    if (received_data_en) begin
                        hold_byte_d = received_data;
                    end
                    timer_d = '0;
                    unique case (state_q)
                        WAIT_ACK: begin
                            if (rx_byte == RSP_ACK)         state_d   = WAIT_BAT;
                            else if (rx_byte == RSP_RESEND) do_resend = 1'b1;
                            else                            do_retry  = 1'b1;
                        end
                        WAIT_BAT: begin
                            if (rx_byte == RSP_BAT_OK) state_d  = WAIT_ID;
                            else                       do_retry = 1'b1;
                        end
                        WAIT_ID: begin
                            if (rx_byte == RSP_ID) state_d  = SEND_EN;
                            else                   do_retry = 1'b1;
                        end
                        default: begin
                            if (rx_byte == RSP_ACK) begin
                                state_d     = STREAM;
                                init_done_d = 1'b1;
                                byte_idx_d  = 2'd0;
                                hold_d      = 1'b0;
                            end else if (rx_byte == RSP_RESEND) begin
                                do_resend = 1'b1;
                            end else begin
                                do_retry = 1'b1;
                            end
                        end
                    endcase
                end else if (timer_q == T_ACK_LAST) begin
                    do_retry = 1'b1;
                end
            end
            STREAM: begin
                if (received_data_en) begin
                    unique case (byte_idx_q)
                        2'd0: begin
                            if (received_data == RSP_BAT_OK) begin
                                // Mouse re-plugged: it has already sent BAT,
                                // its ID byte follows.
                                init_done_d = 1'b0;
                                retry_cnt_d = '0;
                                timer_d     = '0;
                                state_d     = WAIT_ID;
                            end else if (received_data[3]) begin
                                b0_d       = received_data;
                                byte_idx_d = 2'd1;
                                timer_d    = '0;
                            end
                        end
                        2'd1: begin
                            b1_d       = received_data;
                            byte_idx_d = 2'd2;
                            timer_d    = '0;
                        end
                        default: begin
                            b2_d       = received_data;
                            byte_idx_d = 2'd0;
                            timer_d    = '0;
                            pkt_pend_d = 1'b1;
                        end
                    endcase
                end else if (byte_idx_q != 2'd0 && timer_q == T_GAP_LAST) begin
                    byte_idx_d = 2'd0;
                end
            end
            default: begin
                send_command_d = 1'b0;
            end
        endcase

        if (do_retry || do_resend) begin
            retry_cnt_d    = retry_inc;
            send_command_d = 1'b0;
            hold_d         = 1'b0;
            timer_d        = '0;
            if (retry_inc == R_MAX) begin
                state_d      = FAILED;
                init_error_d = 1'b1;
            end else if (do_resend && state_q == WAIT_ACK_EN) begin
                state_d = SEND_EN;
            end else begin
                state_d = SEND_RST;
            end
        end

        if (restart) begin
            state_d        = SEND_RST;
            retry_cnt_d    = '0;
            timer_d        = '0;
            byte_idx_d     = 2'd0;
            send_command_d = 1'b0;
            init_done_d    = 1'b0;
            init_error_d   = 1'b0;
            pkt_pend_d     = 1'b0;
            hold_d         = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q        <= SEND_RST;
            retry_cnt_q    <= '0;
            timer_q        <= '0;
            byte_idx_q     <= 2'd0;
            the_command_q  <= CMD_RESET;
            send_command_q <= 1'b0;
            init_done_q    <= 1'b0;
            init_error_q   <= 1'b0;
            b0_q           <= 8'h00;
            b1_q           <= 8'h00;
            b2_q           <= 8'h00;
            pkt_pend_q     <= 1'b0;
            buttons_q      <= 3'd0;
            dx_q           <= 9'd0;
            dy_q           <= 9'd0;
            overflow_q     <= 2'd0;
            packet_valid_q <= 1'b0;
            hold_q         <= 1'b0;
            hold_byte_q    <= 8'h00;
        end else begin
            state_q        <= state_d;
            retry_cnt_q    <= retry_cnt_d;
            timer_q        <= timer_d;
            byte_idx_q     <= byte_idx_d;
            the_command_q  <= the_command_d;
            send_command_q <= send_command_d;
            init_done_q    <= init_done_d;
            init_error_q   <= init_error_d;
            b0_q           <= b0_d;
            b1_q           <= b1_d;
            b2_q           <= b2_d;
            pkt_pend_q     <= pkt_pend_d;
            buttons_q      <= buttons_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            overflow_q     <= overflow_d;
            packet_valid_q <= packet_valid_d;
            hold_q         <= hold_d;
            hold_byte_q    <= hold_byte_d;
        end
    end

    assign the_command  = the_command_q;
    assign send_command = send_command_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign buttons      = buttons_q;
    assign dx           = dx_q;
    assign dy           = dy_q;
    assign overflow     = overflow_q;
    assign packet_valid = packet_valid_q;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Directed bench for ps2_mouse_sequencer; the bench plays the part of the
// PS2_Controller and the mouse.
module tb_ps2_mouse_sequencer;

    localparam int unsigned TO_CYC  = 1000;
    localparam int unsigned GAP_CYC = 200;
    localparam int unsigned MAX_RT  = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       init_done;
    logic       init_error;
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] overflow;
    logic       packet_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int pv_cnt   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_mouse_sequencer #(
        .TIMEOUT_CYCLES(TO_CYC),
        .PKT_GAP_CYCLES(GAP_CYC),
        .MAX_RETRIES   (MAX_RT)
    ) dut (
        .CLOCK_50                     (CLOCK_50),
        .reset                        (reset),
        .restart                      (restart),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .received_data                (received_data),
        .received_data_en             (received_data_en),
        .init_done                    (init_done),
        .init_error                   (init_error),
        .buttons                      (buttons),
        .dx                           (dx),
        .dy                           (dy),
        .overflow                     (overflow),
        .packet_valid                 (packet_valid)
    );

    always @(negedge CLOCK_50) if (packet_valid === 1'b1) pv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        step();
        received_data_en = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic wait_send(input int bound);
        int n = 0;
        while (send_command !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    // Controller model: accept the request, hold it a few cycles, report sent.
    task automatic do_cmd(input logic [7:0] cmd, input string tag);
        wait_send(50);
        check({tag, "_req"}, 32'(send_command), 32'd1);
        check({tag, "_cmd"}, 32'(the_command), 32'(cmd));
        steps(3);
        check({tag, "_hold"}, 32'({send_command, the_command}), 32'({1'b1, cmd}));
        command_was_sent = 1'b1;
        step();
        command_was_sent = 1'b0;
        check({tag, "_drop"}, 32'(send_command), 32'd0);
    endtask

    task automatic init_tail(input string tag);
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        do_cmd(8'hF4, {tag, "_en"});
        send_byte(8'hFA);
        check({tag, "_done"}, 32'(init_done), 32'd1);
        check({tag, "_noerr"}, 32'(init_error), 32'd0);
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [2:0] e_btn, input logic [8:0] e_dx, input logic [8:0] e_dy,
                       input logic [1:0] e_ovf, input string tag);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        check({tag, "_early"}, 32'(packet_valid), 32'd0);
        step();
        check({tag, "_pv"}, 32'(packet_valid), 32'd1);
        check({tag, "_data"}, 32'({buttons, dx, dy, overflow}), 32'({e_btn, e_dx, e_dy, e_ovf}));
        step();
        check({tag, "_pulse"}, 32'(packet_valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        // reset state
        steps(3);
        check("rst_send", 32'(send_command), 32'd0);
        check("rst_cmd", 32'(the_command), 32'hFF);
        check("rst_flags", 32'({init_done, init_error, packet_valid}), 32'd0);
        check("rst_data", 32'({buttons, dx, dy, overflow}), 32'd0);
        reset = 1'b1;

        // normal bring-up and stream packets
        do_cmd(8'hFF, "i_rst");
        init_tail("i");
        pkt(8'h29, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h1FB, 2'b00, "p1");
        pkt(8'h18, 8'hFF, 8'h01, 3'b000, 9'h1FF, 9'h001, 2'b00, "p2");
        pkt(8'hCF, 8'h12, 8'h34, 3'b111, 9'h012, 9'h034, 2'b11, "p3");

        // resync: byte without bit3 is dropped
        base = pv_cnt;
        send_byte(8'h05);
        pkt(8'h08, 8'h10, 8'h20, 3'b000, 9'h010, 9'h020, 2'b00, "sync");
        check("sync_count", 32'(pv_cnt - base), 32'd1);

        // partial packet dropped after a gap
        base = pv_cnt;
        send_byte(8'h08);
        send_byte(8'h10);
        steps(250);
        pkt(8'h08, 8'h01, 8'h02, 3'b000, 9'h001, 9'h002, 2'b00, "gap");
        check("gap_count", 32'(pv_cnt - base), 32'd1);

        // hot re-plug: AA in byte 0 goes back to waiting for the ID
        send_byte(8'hAA);
        check("hp_down", 32'(init_done), 32'd0);
        send_byte(8'h00);
        do_cmd(8'hF4, "hp_en");
        send_byte(8'hFA);
        check("hp_up", 32'(init_done), 32'd1);

        // restart with a partial packet pending
        base = pv_cnt;
        send_byte(8'h08);
        pulse_restart();
        check("rs_done", 32'(init_done), 32'd0);
        check("rs_send", 32'(send_command), 32'd0);
        check("rs_keep", 32'({dx, dy}), 32'({9'h001, 9'h002}));
        do_cmd(8'hFF, "rs_rst");
        init_tail("rs");
        check("rs_nopkt", 32'(pv_cnt - base), 32'd0);
        pkt(8'h0B, 8'h7F, 8'h80, 3'b011, 9'h07F, 9'h080, 2'b00, "rs_p");

        // resend and retry exhaustion
        pulse_restart();
        do_cmd(8'hFF, "e1");
        send_byte(8'hFE);
        do_cmd(8'hFF, "e2");
        send_byte(8'hFA);
        send_byte(8'hFC);
        check("e_not_yet", 32'(init_error), 32'd0);
        do_cmd(8'hFF, "e3");
        send_byte(8'h55);
        check("e_err", 32'(init_error), 32'd1);
        check("e_send", 32'(send_command), 32'd0);
        steps(20);
        send_byte(8'hFA);
        check("e_sticky", 32'({init_error, init_done, send_command}), 32'b100);
        pulse_restart();
        check("e_clear", 32'(init_error), 32'd0);

        // silent mouse: FF resent after TO_CYC cycles in WAIT_ACK
        do_cmd(8'hFF, "t1");
        n = 0;
        while (send_command !== 1'b1 && n < 1200) begin
            step();
            n++;
        end
        check("to_cycles", 32'(n), 32'd1001);
        check("to_cmd", 32'(the_command), 32'hFF);
        // controller timeout while sending
        error_communication_timed_out = 1'b1;
        step();
        error_communication_timed_out = 1'b0;
        check("ce_drop", 32'(send_command), 32'd0);
        wait_send(50);
        check("ce_resend", 32'({send_command, the_command}), 32'h1FF);
        do_cmd(8'hFF, "t3");
        init_tail("t");

        // reset in the middle of a command
        pulse_restart();
        wait_send(50);
        check("mr_req", 32'(send_command), 32'd1);
        reset = 1'b0;
        step();
        check("mr_send", 32'(send_command), 32'd0);
        check("mr_cmd", 32'(the_command), 32'hFF);
        check("mr_out", 32'({init_done, init_error, packet_valid, buttons, dx, dy, overflow}), 32'd0);
        reset = 1'b1;
        step();
        check("mr_again", 32'(send_command), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
